// File: rtl/tomasula_types.sv
// Shared reservation-station types and default sizing constants.
package tomasula_types;

    localparam int unsigned RS_DEPTH  = 4;
    localparam int unsigned ROB_TAG_W = 3;
    localparam int unsigned CDB_NUM   = 2;
    localparam int unsigned XLEN      = 32;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_LOGIC  = 3'd2,
        OP_SHIFT  = 3'd3,
        OP_SLT    = 3'd4,
        OP_BRANCH = 3'd5,
        OP_LUI    = 3'd6,
        OP_AUIPC  = 3'd7
    } op_t;

    // One station entry at default widths, for tools and models that want a flat view.
    typedef struct packed {
        logic                 busy;
        logic                 ready;
        op_t                  op;
        logic [2:0]           funct3;
        logic                 funct7;
        logic                 src1_valid;
        logic [ROB_TAG_W-1:0] src1_tag;
        logic [XLEN-1:0]      src1_data;
        logic                 src2_valid;
        logic [ROB_TAG_W-1:0] src2_tag;
        logic [XLEN-1:0]      src2_data;
        logic [ROB_TAG_W-1:0] rd_tag;
        logic [31:0]          pc;
    } rs_entry;

endpackage

// File: rtl/rs_age_select.sv
// Age matrix tracking allocation order; grants the oldest requesting entry.
module rs_age_select #(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] alloc_oh,
    input  logic [DEPTH-1:0] free_oh,
    input  logic [DEPTH-1:0] busy,
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant_oh
);

    // older_q[i][j] set means entry j was allocated before entry i and is still live
    logic [DEPTH-1:0] older_q [DEPTH];

    // New entry is younger than every surviving entry; freed entries drop out of all rows
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (alloc_oh[i]) begin
                        older_q[i][j] <= busy[j] & ~free_oh[j];
                    end else if (alloc_oh[j] || free_oh[j]) begin
                        older_q[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    // A requester wins when no older entry is also requesting
    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant_oh[i] = req[i] & ~(|(req & older_q[i]));
        end
    end

endmodule

// File: rtl/res_station_n.sv
// Reservation station: operand wakeup from CDB, oldest-ready issue, flush.
// Optional RS_ISSUE_BYPASS_EN presents a fully-valid allocation on issue in the
// same cycle when nothing stored is ready.
module res_station_n
    import tomasula_types::*;
#(
    parameter int unsigned DEPTH   = RS_DEPTH,
    parameter int unsigned TAG_W   = ROB_TAG_W,
    parameter int unsigned NUM_CDB = CDB_NUM,
    parameter int unsigned DATA_W  = XLEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  op_t                          alloc_op,
    input  logic [2:0]                   alloc_funct3,
    input  logic                         alloc_funct7,
    input  logic                         alloc_src1_valid,
    input  logic [TAG_W-1:0]             alloc_src1_tag,
    input  logic [DATA_W-1:0]            alloc_src1_data,
    input  logic                         alloc_src2_valid,
    input  logic [TAG_W-1:0]             alloc_src2_tag,
    input  logic [DATA_W-1:0]            alloc_src2_data,
    input  logic [TAG_W-1:0]             alloc_rd_tag,
    input  logic [31:0]                  alloc_pc,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]     cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]    cdb_data,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output op_t                          issue_op,
    output logic [2:0]                   issue_funct3,
    output logic                         issue_funct7,
    output logic [DATA_W-1:0]            issue_src1,
    output logic [DATA_W-1:0]            issue_src2,
    output logic [31:0]                  issue_pc,
    output logic [TAG_W-1:0]             issue_tag,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  busy_q, rdy_q, s1_v_q, s2_v_q, f7_q;
    logic [TAG_W-1:0]  s1_tag_q  [DEPTH];
    logic [TAG_W-1:0]  s2_tag_q  [DEPTH];
    logic [DATA_W-1:0] s1_data_q [DEPTH];
    logic [DATA_W-1:0] s2_data_q [DEPTH];
    logic [TAG_W-1:0]  rd_q      [DEPTH];
    logic [31:0]       pc_q      [DEPTH];
    logic [2:0]        f3_q      [DEPTH];
    op_t               op_q      [DEPTH];
    logic [CNT_W-1:0]  count_q;

    logic [DATA_W:0]   wk1 [DEPTH];
    logic [DATA_W:0]   wk2 [DEPTH];
    logic [DATA_W:0]   al1, al2;
    logic              a1_v, a2_v;
    logic [DATA_W-1:0] a1_d, a2_d;
    logic [DEPTH-1:0]  free_oh, grant_oh, alloc_oh, issue_oh, age_free;
    logic              any_rdy, bypass, issue_fire, entry_issue, alloc_fire, store;

    // {hit, data} for a tag against the broadcast channels; lowest channel wins
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]          tag,
        input logic [NUM_CDB-1:0]        valid,
        input logic [NUM_CDB*TAG_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] data
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int c = int'(NUM_CDB) - 1; c >= 0; c--) begin
            if (valid[c] && (tags[c*TAG_W +: TAG_W] == tag)) begin
                r = {1'b1, data[c*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    // CDB matches for stored operands and for the allocating instruction
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wk1[i] = cdb_lookup(s1_tag_q[i], cdb_valid, cdb_tag, cdb_data);
            wk2[i] = cdb_lookup(s2_tag_q[i], cdb_valid, cdb_tag, cdb_data);
        end
        al1  = cdb_lookup(alloc_src1_tag, cdb_valid, cdb_tag, cdb_data);
        al2  = cdb_lookup(alloc_src2_tag, cdb_valid, cdb_tag, cdb_data);
        a1_v = alloc_src1_valid | al1[DATA_W];
        a2_v = alloc_src2_valid | al2[DATA_W];
        a1_d = alloc_src1_valid ? alloc_src1_data : al1[DATA_W-1:0];
        a2_d = alloc_src2_valid ? alloc_src2_data : al2[DATA_W-1:0];
    end

    // Lowest-index free slot
    always_comb begin
        free_oh = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_oh = '0;
                free_oh[i] = 1'b1;
            end
        end
    end

    assign alloc_ready = |(~busy_q);
    assign any_rdy     = |rdy_q;
    assign count       = count_q;

    rs_age_select #(.DEPTH(DEPTH)) u_age (
        .clk      (clk),
        .rst      (rst),
        .alloc_oh (alloc_oh),
        .free_oh  (age_free),
        .busy     (busy_q),
        .req      (rdy_q),
        .grant_oh (grant_oh)
    );

    // Handshake decode and issue mux
    always_comb begin
`ifdef RS_ISSUE_BYPASS_EN
        bypass = alloc_valid & alloc_ready & ~flush & ~any_rdy & a1_v & a2_v;
`else
        bypass = 1'b0;
`endif
        issue_valid  = ~flush & (any_rdy | bypass);
        issue_fire   = issue_valid & issue_ready;
        entry_issue  = issue_fire & ~bypass;
        alloc_fire   = alloc_valid & alloc_ready & ~flush;
        store        = alloc_fire & ~(bypass & issue_ready);
        alloc_oh     = store ? free_oh : '0;
        issue_oh     = entry_issue ? grant_oh : '0;
        age_free     = flush ? '1 : issue_oh;

        issue_op     = OP_ADD;
        issue_funct3 = '0;
        issue_funct7 = 1'b0;
        issue_src1   = '0;
        issue_src2   = '0;
        issue_pc     = '0;
        issue_tag    = '0;
        if (bypass) begin
            issue_op     = alloc_op;
            issue_funct3 = alloc_funct3;
            issue_funct7 = alloc_funct7;
            issue_src1   = a1_d;
            issue_src2   = a2_d;
            issue_pc     = alloc_pc;
            issue_tag    = alloc_rd_tag;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (grant_oh[i]) begin
                    issue_op     = op_q[i];
                    issue_funct3 = f3_q[i];
                    issue_funct7 = f7_q[i];
                    issue_src1   = s1_data_q[i];
                    issue_src2   = s2_data_q[i];
                    issue_pc     = pc_q[i];
                    issue_tag    = rd_q[i];
                end
            end
        end
    end

    // Entry storage: write on alloc, free on issue, capture CDB, ready lags operands by a cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q  <= '0;
            rdy_q   <= '0;
            s1_v_q  <= '0;
            s2_v_q  <= '0;
            f7_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                s1_tag_q[i]  <= '0;
                s2_tag_q[i]  <= '0;
                s1_data_q[i] <= '0;
                s2_data_q[i] <= '0;
                rd_q[i]      <= '0;
                pc_q[i]      <= '0;
                f3_q[i]      <= '0;
                op_q[i]      <= OP_ADD;
            end
        end else if (flush) begin
            busy_q  <= '0;
            rdy_q   <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(store) - CNT_W'(entry_issue);
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_oh[i]) begin
                    busy_q[i]    <= 1'b1;
                    rdy_q[i]     <= a1_v & a2_v;
                    s1_v_q[i]    <= a1_v;
                    s2_v_q[i]    <= a2_v;
                    s1_tag_q[i]  <= alloc_src1_tag;
                    s2_tag_q[i]  <= alloc_src2_tag;
                    s1_data_q[i] <= a1_d;
                    s2_data_q[i] <= a2_d;
                    rd_q[i]      <= alloc_rd_tag;
                    pc_q[i]      <= alloc_pc;
                    f3_q[i]      <= alloc_funct3;
                    f7_q[i]      <= alloc_funct7;
                    op_q[i]      <= alloc_op;
                end else if (issue_oh[i]) begin
                    busy_q[i] <= 1'b0;
                    rdy_q[i]  <= 1'b0;
                end else if (busy_q[i]) begin
                    rdy_q[i] <= s1_v_q[i] & s2_v_q[i];
                    if (!s1_v_q[i] && wk1[i][DATA_W]) begin
                        s1_v_q[i]    <= 1'b1;
                        s1_data_q[i] <= wk1[i][DATA_W-1:0];
                    end
                    if (!s2_v_q[i] && wk2[i][DATA_W]) begin
                        s2_v_q[i]    <= 1'b1;
                        s2_data_q[i] <= wk2[i][DATA_W-1:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_res_station_n.sv
// Randomized bench for res_station_n against an in-order queue model.
module tb_res_station_n;
    import tomasula_types::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TAG_W   = 3;
    localparam int unsigned NUM_CDB = 2;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      alloc_valid, alloc_ready;
    op_t                       alloc_op;
    logic [2:0]                alloc_funct3;
    logic                      alloc_funct7;
    logic                      alloc_src1_valid, alloc_src2_valid;
    logic [TAG_W-1:0]          alloc_src1_tag, alloc_src2_tag, alloc_rd_tag;
    logic [DATA_W-1:0]         alloc_src1_data, alloc_src2_data;
    logic [31:0]               alloc_pc;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_data;
    logic                      issue_valid, issue_ready;
    op_t                       issue_op;
    logic [2:0]                issue_funct3;
    logic                      issue_funct7;
    logic [DATA_W-1:0]         issue_src1, issue_src2;
    logic [31:0]               issue_pc;
    logic [TAG_W-1:0]          issue_tag;
    logic                      flush;
    logic [CNT_W-1:0]          count;

    always #5 clk = ~clk;

    res_station_n #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
        .alloc_funct3(alloc_funct3), .alloc_funct7(alloc_funct7),
        .alloc_src1_valid(alloc_src1_valid), .alloc_src1_tag(alloc_src1_tag), .alloc_src1_data(alloc_src1_data),
        .alloc_src2_valid(alloc_src2_valid), .alloc_src2_tag(alloc_src2_tag), .alloc_src2_data(alloc_src2_data),
        .alloc_rd_tag(alloc_rd_tag), .alloc_pc(alloc_pc),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
        .issue_src1(issue_src1), .issue_src2(issue_src2), .issue_pc(issue_pc), .issue_tag(issue_tag),
        .flush(flush), .count(count)
    );

    // Model entry; queue order is allocation order
    typedef struct {
        op_t               op;
        logic [2:0]        f3;
        logic              f7;
        bit                v1, v2;
        logic [TAG_W-1:0]  t1, t2, rd;
        logic [DATA_W-1:0] d1, d2;
        logic [31:0]       pc;
        bit                elig;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit cdb_hit(input logic [TAG_W-1:0] t, output logic [DATA_W-1:0] d);
        d = '0;
        for (int c = 0; c < NUM_CDB; c++) begin
            if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == t) begin
                d = cdb_data[c*DATA_W +: DATA_W];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic idle();
        alloc_valid = 0; alloc_op = OP_ADD; alloc_funct3 = '0; alloc_funct7 = 0;
        alloc_src1_valid = 0; alloc_src1_tag = '0; alloc_src1_data = '0;
        alloc_src2_valid = 0; alloc_src2_tag = '0; alloc_src2_data = '0;
        alloc_rd_tag = '0; alloc_pc = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        issue_ready = 0; flush = 0;
    endtask

    task automatic set_alloc(input op_t op, input bit v1, input int t1, input logic [31:0] d1,
                             input bit v2, input int t2, input logic [31:0] d2,
                             input int rd, input logic [31:0] pc);
        alloc_valid = 1; alloc_op = op; alloc_funct3 = 3'(rd); alloc_funct7 = rd[0];
        alloc_src1_valid = v1; alloc_src1_tag = TAG_W'(t1); alloc_src1_data = d1;
        alloc_src2_valid = v2; alloc_src2_tag = TAG_W'(t2); alloc_src2_data = d2;
        alloc_rd_tag = TAG_W'(rd); alloc_pc = pc;
    endtask

    task automatic cdb_set(input int ch, input int t, input logic [31:0] d);
        cdb_valid[ch] = 1'b1;
        cdb_tag[ch*TAG_W +: TAG_W] = TAG_W'(t);
        cdb_data[ch*DATA_W +: DATA_W] = d;
    endtask

    // Check outputs against the model, then advance the model across one clock edge
    task automatic step();
        ent_t              ae, e;
        int                idx;
        bit                ev, do_alloc;
        logic [DATA_W-1:0] d;
        #1;
        idx = -1;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].elig) begin
                idx = i;
                break;
            end
        end
        ev = !flush && (idx >= 0);
        check("alloc_ready", 64'(alloc_ready), 64'(q.size() < DEPTH));
        check("count", 64'(count), 64'(q.size()));
        check("issue_valid", 64'(issue_valid), 64'(ev));
        if (ev) begin
            e = q[idx];
            check("issue_tag", 64'(issue_tag), 64'(e.rd));
            check("issue_src1", 64'(issue_src1), 64'(e.d1));
            check("issue_src2", 64'(issue_src2), 64'(e.d2));
            check("issue_pc", 64'(issue_pc), 64'(e.pc));
            check("issue_op", 64'(issue_op), 64'(e.op));
            check("issue_funct", 64'({issue_funct3, issue_funct7}), 64'({e.f3, e.f7}));
        end
        do_alloc = alloc_valid && (q.size() < DEPTH);
        ae.op = alloc_op; ae.f3 = alloc_funct3; ae.f7 = alloc_funct7;
        ae.v1 = alloc_src1_valid; ae.t1 = alloc_src1_tag; ae.d1 = alloc_src1_data;
        ae.v2 = alloc_src2_valid; ae.t2 = alloc_src2_tag; ae.d2 = alloc_src2_data;
        ae.rd = alloc_rd_tag; ae.pc = alloc_pc;
        if (!ae.v1 && cdb_hit(ae.t1, d)) begin ae.v1 = 1; ae.d1 = d; end
        if (!ae.v2 && cdb_hit(ae.t2, d)) begin ae.v2 = 1; ae.d2 = d; end
        ae.elig = ae.v1 && ae.v2;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (ev && issue_ready) q.delete(idx);
            for (int i = 0; i < q.size(); i++) begin
                q[i].elig = q[i].v1 && q[i].v2;
                if (!q[i].v1 && cdb_hit(q[i].t1, d)) begin q[i].v1 = 1; q[i].d1 = d; end
                if (!q[i].v2 && cdb_hit(q[i].t2, d)) begin q[i].v2 = 1; q[i].d2 = d; end
            end
            if (do_alloc) q.push_back(ae);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 8; k++) begin
            idle(); issue_ready = 1; step();
        end
    endtask

    initial begin
        idle();
        rst = 0;
        repeat (3) @(negedge clk);
        check("rst_issue_valid", 64'(issue_valid), 64'(0));
        check("rst_alloc_ready", 64'(alloc_ready), 64'(1));
        check("rst_count", 64'(count), 64'(0));
        check("rst_issue_data", 64'({issue_src1, issue_tag}), 64'(0));
        check("rst_issue_pc", 64'(issue_pc), 64'(0));
        rst = 1;
        @(negedge clk);

        // Wakeup via CDB: eligible two cycles after the broadcast
        idle(); issue_ready = 1; set_alloc(OP_ADD, 1, 0, 5, 0, 2, 0, 4, 32'h100); step();
        idle(); issue_ready = 1; cdb_set(0, 2, 7); step();
        idle(); issue_ready = 1; #1 check("wake_early", 64'(issue_valid), 64'(0)); step();
        idle(); issue_ready = 1; #1;
        check("wake_valid", 64'(issue_valid), 64'(1));
        check("wake_src2", 64'(issue_src2), 64'(7));
        check("wake_src1", 64'(issue_src1), 64'(5));
        check("wake_tag", 64'(issue_tag), 64'(4));
        step();

        // Capture during the allocation cycle on channel 1
        idle(); issue_ready = 1; set_alloc(OP_SUB, 0, 3, 0, 1, 0, 9, 5, 32'h200); cdb_set(1, 3, 32'hDEAD); step();
        idle(); issue_ready = 1; #1;
        check("alloc_cap_valid", 64'(issue_valid), 64'(1));
        check("alloc_cap_src1", 64'(issue_src1), 64'(32'hDEAD));
        step();

        // Fill, ignored fifth alloc, one issue frees a slot
        for (int k = 0; k < 4; k++) begin
            idle(); set_alloc(OP_LOGIC, 1, 0, 32'(k), 1, 0, 32'(k + 10), k, 32'(k * 4)); step();
        end
        idle(); #1;
        check("full_ready", 64'(alloc_ready), 64'(0));
        check("full_count", 64'(count), 64'(4));
        set_alloc(OP_SLT, 1, 0, 1, 1, 0, 2, 7, 32'h300); step();
        idle(); issue_ready = 1; #1 check("full_oldest", 64'(issue_tag), 64'(0)); step();
        idle(); #1;
        check("after_issue_ready", 64'(alloc_ready), 64'(1));
        check("after_issue_count", 64'(count), 64'(3));
        step();
        drain();

        // Age order between two ready entries
        idle(); set_alloc(OP_ADD, 1, 0, 1, 1, 0, 2, 1, 32'h10); step();
        idle(); set_alloc(OP_ADD, 1, 0, 3, 1, 0, 4, 2, 32'h14); step();
        idle(); issue_ready = 1; #1 check("age_first", 64'(issue_tag), 64'(1)); step();
        idle(); issue_ready = 1; #1 check("age_second", 64'(issue_tag), 64'(2)); step();

        // Two channels match the same tag: channel 0 wins
        idle(); set_alloc(OP_SHIFT, 0, 1, 0, 1, 0, 3, 6, 32'h20); step();
        idle(); cdb_set(0, 1, 10); cdb_set(1, 1, 20); step();
        idle(); step();
        idle(); issue_ready = 1; #1 check("prio_src1", 64'(issue_src1), 64'(10)); step();

        // Flush with three ready entries
        for (int k = 0; k < 3; k++) begin
            idle(); set_alloc(OP_BRANCH, 1, 0, 1, 1, 0, 1, k, 32'h40); step();
        end
        idle(); flush = 1; issue_ready = 1; #1 check("flush_issue_valid", 64'(issue_valid), 64'(0)); step();
        idle(); #1;
        check("flush_count", 64'(count), 64'(0));
        check("flush_alloc_ready", 64'(alloc_ready), 64'(1));
        step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            alloc_valid      = ($urandom_range(0, 9) < 6);
            alloc_op         = op_t'(3'($urandom_range(0, 7)));
            alloc_funct3     = 3'($urandom);
            alloc_funct7     = 1'($urandom);
            alloc_src1_valid = 1'($urandom);
            alloc_src2_valid = 1'($urandom);
            alloc_src1_tag   = TAG_W'($urandom);
            alloc_src2_tag   = TAG_W'($urandom);
            alloc_src1_data  = $urandom;
            alloc_src2_data  = $urandom;
            alloc_rd_tag     = TAG_W'($urandom);
            alloc_pc         = $urandom;
            for (int c = 0; c < NUM_CDB; c++) begin
                if ($urandom_range(0, 2) == 0) cdb_set(c, int'($urandom_range(0, 7)), $urandom);
            end
            issue_ready = ($urandom_range(0, 9) < 5);
            flush       = ($urandom_range(0, 99) < 2);
            step();
        end

        // Asynchronous reset with live entries
        for (int k = 0; k < 3; k++) begin
            idle(); set_alloc(OP_AUIPC, 1, 0, 2, 1, 0, 3, k, 32'h80); step();
        end
        idle(); issue_ready = 1;
        #2 rst = 0;
        #1;
        check("midrst_issue_valid", 64'(issue_valid), 64'(0));
        check("midrst_count", 64'(count), 64'(0));
        check("midrst_alloc_ready", 64'(alloc_ready), 64'(1));
        q.delete();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            idle(); issue_ready = 1; step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
